// File: rtl/melody_pkg.sv
// Shared types for the melody sequencer: note codes, durations, FSM states,
// ROM entry layout and the tempo-scaled duration helper.
package melody_pkg;

  localparam logic [2:0] NOTE_A_HIGH = 3'd0;
  localparam logic [2:0] NOTE_E_HIGH = 3'd1;
  localparam logic [2:0] NOTE_B      = 3'd2;
  localparam logic [2:0] NOTE_G      = 3'd3;
  localparam logic [2:0] NOTE_D      = 3'd4;
  localparam logic [2:0] NOTE_A      = 3'd5;
  localparam logic [2:0] NOTE_E_LOW  = 3'd6;
  localparam logic [2:0] NOTE_B_LOW  = 3'd7;

  localparam int SONG_LEN = 8;

  typedef enum logic [1:0] {
    DUR_EIGHTH  = 2'd0,
    DUR_QUARTER = 2'd1,
    DUR_HALF    = 2'd2,
    DUR_WHOLE   = 2'd3
  } dur_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PLAY = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  typedef struct packed {
    logic       rest;
    logic [2:0] note;
    dur_e       dur;
  } rom_entry_t;

  // Tempo 01 doubles every duration, 10 halves it; 00 and 11 leave it alone.
  function automatic logic [31:0] dur_cycles(dur_e dur, logic [1:0] tempo, logic [31:0] q);
    logic [31:0] base;
    case (dur)
      DUR_EIGHTH:  base = q >> 1;
      DUR_QUARTER: base = q;
      DUR_HALF:    base = q << 1;
      default:     base = q << 2;
    endcase
    case (tempo)
      2'b01:   dur_cycles = base << 1;
      2'b10:   dur_cycles = base >> 1;
      default: dur_cycles = base;
    endcase
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Combinational 8-entry song table: step address to {rest, note, duration}.
module melody_rom
  import melody_pkg::*;
(
  input  logic [2:0] addr_i,
  output rom_entry_t entry_o
);

  always_comb begin
    entry_o = '{rest: 1'b1, note: NOTE_A_HIGH, dur: DUR_EIGHTH};
    case (addr_i)
      3'd0: entry_o = '{rest: 1'b0, note: NOTE_E_LOW,  dur: DUR_QUARTER};
      3'd1: entry_o = '{rest: 1'b0, note: NOTE_A,      dur: DUR_QUARTER};
      3'd2: entry_o = '{rest: 1'b0, note: NOTE_D,      dur: DUR_QUARTER};
      3'd3: entry_o = '{rest: 1'b0, note: NOTE_G,      dur: DUR_QUARTER};
      3'd4: entry_o = '{rest: 1'b0, note: NOTE_B,      dur: DUR_QUARTER};
      3'd5: entry_o = '{rest: 1'b0, note: NOTE_E_HIGH, dur: DUR_HALF};
      3'd6: entry_o = '{rest: 1'b1, note: NOTE_A_HIGH, dur: DUR_EIGHTH};
      3'd7: entry_o = '{rest: 1'b0, note: NOTE_A_HIGH, dur: DUR_WHOLE};
      default: ;
    endcase
  end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the song ROM driving a one-hot note select with a silent gap per step.
// Optional SEQ_PAUSE_EN adds a pause input that freezes PLAY/GAP and mutes the output.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned QUARTER_NOTE = 25_000_000,
  parameter int unsigned GAP_CYCLES   = 1_250_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  input  logic [1:0] tempo_sel,
`ifdef SEQ_PAUSE_EN
  input  logic       pause,
`endif
  output logic [7:0] note_sel,
  output logic [2:0] step_idx,
  output logic       busy,
  output logic       done
);

  if (GAP_CYCLES >= QUARTER_NOTE / 4) begin : g_gap_check
    $error("GAP_CYCLES must be less than QUARTER_NOTE/4");
  end

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] dur_q, dur_d;
  logic [2:0]  step_q, step_d;
  logic [2:0]  note_q, note_d;
  logic        rest_q, rest_d;
  logic [7:0]  note_sel_q, note_sel_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pause_w;
  rom_entry_t  rom_entry;
  logic [2:0]  cur_note;
  logic        cur_rest;

`ifdef SEQ_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  melody_rom u_rom (
    .addr_i  (step_q),
    .entry_o (rom_entry)
  );

  // During LOAD the latched note is not yet valid, so take it straight from the ROM.
  assign cur_note = (state_q == S_LOAD) ? rom_entry.note : note_q;
  assign cur_rest = (state_q == S_LOAD) ? rom_entry.rest : rest_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dur_d   = dur_q;
    step_d  = step_q;
    note_d  = note_q;
    rest_d  = rest_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_LOAD;
          step_d  = 3'd0;
        end
      end
      S_LOAD: begin
        note_d  = rom_entry.note;
        rest_d  = rom_entry.rest;
        dur_d   = dur_cycles(rom_entry.dur, tempo_sel, 32'(QUARTER_NOTE));
        cnt_d   = 32'd0;
        state_d = S_PLAY;
      end
      S_PLAY: begin
        if (!pause_w) begin
          if (cnt_q == dur_q - 32'(GAP_CYCLES) - 32'd1) begin
            state_d = S_GAP;
            cnt_d   = 32'd0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      S_GAP: begin
        if (!pause_w) begin
          if (cnt_q == 32'(GAP_CYCLES) - 32'd1) begin
            cnt_d = 32'd0;
            if (step_q != 3'(SONG_LEN - 1)) begin
              step_d  = step_q + 3'd1;
              state_d = S_LOAD;
            end else if (loop_en) begin
              step_d  = 3'd0;
              state_d = S_LOAD;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        step_d  = 3'd0;
      end
      default: state_d = S_IDLE;
    endcase

    // Stop overrides everything, including pause.
    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      step_d  = 3'd0;
      cnt_d   = 32'd0;
    end

    // Outputs are registered, so they are decoded from the next state.
    note_sel_d = 8'd0;
    if (state_d == S_PLAY && !pause_w && !cur_rest) begin
      note_sel_d = 8'd1 << cur_note;
    end
    busy_d = (state_d == S_LOAD) || (state_d == S_PLAY) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= 32'd0;
      dur_q      <= 32'd0;
      step_q     <= 3'd0;
      note_q     <= 3'd0;
      rest_q     <= 1'b0;
      note_sel_q <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dur_q      <= dur_d;
      step_q     <= step_d;
      note_q     <= note_d;
      rest_q     <= rest_d;
      note_sel_q <= note_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign note_sel = note_sel_q;
  assign step_idx = step_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
